// File: rtl/segment_scanner.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// Presents one nibble per slot and blanks all anodes at the start of each slot.
module segment_scanner #(
    parameter int digits       = 4,
    parameter int prescale     = 1000,
    parameter int blank_cycles = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [digits*4-1:0]   value,
    input  logic                  load,
    input  logic                  leading_blank,
    output logic [3:0]            number,
    output logic [digits-1:0]     digit_enable,
    output logic                  frame_done
);

    localparam int CW = (prescale > 1) ? $clog2(prescale) : 1;
    localparam int IW = (digits > 1) ? $clog2(digits) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(prescale - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(blank_cycles);
    localparam logic [IW-1:0] LAST_INDEX = IW'(digits - 1);

    logic [CW-1:0]          count_q, count_d;
    logic [IW-1:0]          index_q, index_d;
    logic [digits*4-1:0]    shadow_q, shadow_d;
    logic [digits*4-1:0]    display_q, display_d;
    logic                   pending_q, pending_d;
    logic [3:0]             number_q, number_d;
    logic [digits-1:0]      enable_q, enable_d;
    logic                   frameDone_q, frameDone_d;

    logic                   slotEnd;
    logic                   frameEnd;
    logic                   suppress;
    logic                   zeroAcc;
    logic [digits-1:0]      upperZero;

    // Outputs are computed from next-state values so the registered outputs
    // always describe the slot the counter is currently in.
    always_comb begin
        slotEnd  = (count_q == LAST_COUNT);
        frameEnd = slotEnd && (index_q == LAST_INDEX);

        count_d = slotEnd ? '0 : count_q + CW'(1);
        index_d = index_q;
        if (slotEnd) begin
            index_d = (index_q == LAST_INDEX) ? '0 : index_q + IW'(1);
        end

        shadow_d  = load ? value : shadow_q;
        display_d = display_q;
        pending_d = pending_q | load;
        // A load landing on the frame boundary bypasses the stale shadow.
        if (frameEnd) begin
            if (load) begin
                display_d = value;
            end else if (pending_q) begin
                display_d = shadow_q;
            end
            pending_d = 1'b0;
        end

        zeroAcc   = 1'b1;
        upperZero = '0;
        for (int i = digits - 1; i >= 0; i--) begin
            zeroAcc      = zeroAcc && (display_d[i*4 +: 4] == 4'h0);
            upperZero[i] = zeroAcc;
        end

        suppress = leading_blank && (index_d != '0) && upperZero[index_d];
        number_d = display_d[index_d*4 +: 4];
        enable_d = '1;
        if ((count_d >= BLANK_END) && !suppress) begin
            enable_d[index_d] = 1'b0;
        end
        frameDone_d = (count_d == LAST_COUNT) && (index_d == LAST_INDEX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            index_q     <= '0;
            shadow_q    <= '0;
            display_q   <= '0;
            pending_q   <= 1'b0;
            number_q    <= 4'h0;
            enable_q    <= '1;
            frameDone_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            index_q     <= index_d;
            shadow_q    <= shadow_d;
            display_q   <= display_d;
            pending_q   <= pending_d;
            number_q    <= number_d;
            enable_q    <= enable_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign number       = number_q;
    assign digit_enable = enable_q;
    assign frame_done   = frameDone_q;

endmodule
